// File: rtl/seg7_scan_display_pkg.sv
// rtl/seg7_scan_display_pkg.sv - shared FSM states and 7-segment pattern constants
// Purpose: state encoding for the scan FSM and the active-high {g,f,e,d,c,b,a}
//          glyph patterns used by the decoder.
// Ports:   none (package)
package seg7_scan_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Code fed to the decoder for a digit hidden by leading-zero suppression.
  localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_scan_display_decoder.sv
// rtl/seg7_scan_display_decoder.sv - BCD code to active-high 7-segment pattern
// Purpose: purely combinational glyph lookup; codes 10..15 render dark.
// Ports:
//   i_Code     in  4  BCD digit code
//   o_Pattern  out 7  active-high {g,f,e,d,c,b,a}
module seg7_scan_display_decoder (
  input  logic [3:0] i_Code,
  output logic [6:0] o_Pattern
);
  import seg7_scan_display_pkg::*;

  always_comb begin
    o_Pattern = SEG_BLANK;
    case (i_Code)
      4'd0:    o_Pattern = SEG_0;
      4'd1:    o_Pattern = SEG_1;
      4'd2:    o_Pattern = SEG_2;
      4'd3:    o_Pattern = SEG_3;
      4'd4:    o_Pattern = SEG_4;
      4'd5:    o_Pattern = SEG_5;
      4'd6:    o_Pattern = SEG_6;
      4'd7:    o_Pattern = SEG_7;
      4'd8:    o_Pattern = SEG_8;
      4'd9:    o_Pattern = SEG_9;
      default: o_Pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed common-anode 7-segment scanner
// Purpose: snapshots BCD digits once per frame and scans them one slot at a
//          time, each slot starting with a dark gap to avoid ghosting.
// Ports:
//   i_Clock        in  1           system clock
//   i_Reset_n      in  1           async active-low reset
//   i_Enable       in  1           1 = scanning, 0 = dark
//   i_Digits       in  4*c_DIGITS  BCD digits, digit k at [4k+3:4k]
//   i_Dot_Mask     in  c_DIGITS    per-digit decimal point
//   i_Blank_Zero   in  1           suppress leading zeros
//   o_Segments     out 7           segment drive {g,f,e,d,c,b,a}
//   o_Dot          out 1           decimal-point drive
//   o_Anodes       out c_DIGITS    digit select
//   o_Frame_Start  out 1           pulse on each new snapshot
module seg7_scan_display #(
  parameter int c_DIGITS         = 4,
  parameter int c_SCAN_DIV       = 25000,
  parameter int c_BLANK_CYCLES   = 16,
  parameter int c_SEG_ACTIVE_LOW = 1,
  parameter int c_AN_ACTIVE_LOW  = 1
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_Enable,
  input  logic [4*c_DIGITS-1:0]   i_Digits,
  input  logic [c_DIGITS-1:0]     i_Dot_Mask,
  input  logic                    i_Blank_Zero,
  output logic [6:0]              o_Segments,
  output logic                    o_Dot,
  output logic [c_DIGITS-1:0]     o_Anodes,
  output logic                    o_Frame_Start
);
  import seg7_scan_display_pkg::*;

  localparam int c_IDX_W = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;
  localparam int c_TMR_W = $clog2(c_SCAN_DIV);

  localparam logic [6:0]          c_SEG_OFF = (c_SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                c_DOT_OFF = (c_SEG_ACTIVE_LOW != 0);
  localparam logic [c_DIGITS-1:0] c_AN_OFF  = (c_AN_ACTIVE_LOW != 0) ? {c_DIGITS{1'b1}} : '0;

  state_t                  r_state;
  logic [c_TMR_W-1:0]      r_timer;
  logic [c_IDX_W-1:0]      r_index;
  logic [4*c_DIGITS-1:0]   r_digits;
  logic [c_DIGITS-1:0]     r_dots;
  logic [c_DIGITS-1:0]     r_zero_mask;
  logic [6:0]              r_segments;
  logic                    r_dot;
  logic [c_DIGITS-1:0]     r_anodes;
  logic                    r_frame_start;

  logic                    w_blank_end;
  logic                    w_slot_end;
  logic                    w_last_slot;
  logic                    w_snap;
  logic [3:0]              w_sel_code;
  logic                    w_sel_dot;
  logic                    w_sel_blank;
  logic [c_DIGITS-1:0]     w_an_sel;
  logic [c_DIGITS-1:0]     w_zero_mask;
  logic                    w_upper_zero;
  logic [3:0]              w_code;
  logic [6:0]              w_pattern;
  logic [6:0]              w_seg_lit;
  logic                    w_dot_lit;
  logic [c_DIGITS-1:0]     w_an_lit;

  // The timer runs across the whole slot: dark for the first c_BLANK_CYCLES
  // counts, lit for the rest.
  assign w_blank_end = (r_timer == c_TMR_W'(c_BLANK_CYCLES - 1));
  assign w_slot_end  = (r_timer == c_TMR_W'(c_SCAN_DIV - 1));
  assign w_last_slot = (r_index == c_IDX_W'(c_DIGITS - 1));

  // A snapshot accompanies every entry into slot 0's blank phase.
  assign w_snap = i_Enable &&
                  ((r_state == S_IDLE) || (r_state == S_SHOW && w_slot_end && w_last_slot));

  always_comb begin
    w_sel_code  = 4'h0;
    w_sel_dot   = 1'b0;
    w_sel_blank = 1'b0;
    w_an_sel    = '0;
    for (int k = 0; k < c_DIGITS; k++) begin
      if (r_index == c_IDX_W'(k)) begin
        w_sel_code  = r_digits[4*k +: 4];
        w_sel_dot   = r_dots[k];
        w_sel_blank = r_zero_mask[k];
        w_an_sel[k] = 1'b1;
      end
    end
  end

  // Digit k is suppressed when it and all higher digits are zero; digit 0 never is.
  always_comb begin
    w_zero_mask  = '0;
    w_upper_zero = 1'b1;
    for (int k = c_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero   = w_upper_zero & (i_Digits[4*k +: 4] == 4'h0);
      w_zero_mask[k] = i_Blank_Zero & w_upper_zero;
    end
  end

  assign w_code = w_sel_blank ? CODE_BLANK : w_sel_code;

  seg7_scan_display_decoder u_decoder (
    .i_Code    (w_code),
    .o_Pattern (w_pattern)
  );

  assign w_seg_lit = (c_SEG_ACTIVE_LOW != 0) ? ~w_pattern : w_pattern;
  assign w_dot_lit = (c_SEG_ACTIVE_LOW != 0) ? ~w_sel_dot : w_sel_dot;
  assign w_an_lit  = (c_AN_ACTIVE_LOW != 0)  ? ~w_an_sel  : w_an_sel;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_digits    <= '0;
      r_dots      <= '0;
      r_zero_mask <= '0;
    end else if (w_snap) begin
      r_digits    <= i_Digits;
      r_dots      <= i_Dot_Mask;
      r_zero_mask <= w_zero_mask;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_index       <= '0;
      r_segments    <= c_SEG_OFF;
      r_dot         <= c_DOT_OFF;
      r_anodes      <= c_AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      if (!i_Enable) begin
        r_state    <= S_IDLE;
        r_timer    <= '0;
        r_index    <= '0;
        r_segments <= c_SEG_OFF;
        r_dot      <= c_DOT_OFF;
        r_anodes   <= c_AN_OFF;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_BLANK;
            r_timer    <= '0;
            r_index    <= '0;
            r_segments <= c_SEG_OFF;
            r_dot      <= c_DOT_OFF;
            r_anodes   <= c_AN_OFF;
          end
          S_BLANK: begin
            r_timer <= r_timer + c_TMR_W'(1);
            if (w_blank_end) begin
              r_state    <= S_SHOW;
              r_segments <= w_seg_lit;
              r_dot      <= w_dot_lit;
              r_anodes   <= w_an_lit;
            end
          end
          S_SHOW: begin
            if (w_slot_end) begin
              r_state    <= S_BLANK;
              r_timer    <= '0;
              r_index    <= w_last_slot ? '0 : r_index + c_IDX_W'(1);
              r_segments <= c_SEG_OFF;
              r_dot      <= c_DOT_OFF;
              r_anodes   <= c_AN_OFF;
            end else begin
              r_timer <= r_timer + c_TMR_W'(1);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_index    <= '0;
            r_segments <= c_SEG_OFF;
            r_dot      <= c_DOT_OFF;
            r_anodes   <= c_AN_OFF;
          end
        endcase
      end
    end
  end

  assign o_Segments    = r_segments;
  assign o_Dot         = r_dot;
  assign o_Anodes      = r_anodes;
  assign o_Frame_Start = r_frame_start;

endmodule
